// File: rtl/ber_monitor.sv
// ber_monitor: bit-error-rate checker comparing queued reference words against decoded words.
// Latency: counters/flags update on the edge after a compare; DONE/PASS one edge after window end or STOP.
// Backpressure: o_tx_ready drops when the reference FIFO is full or outside RUN; RX side has none.
//
// Ports:
//   i_clk, i_reset         rising-edge clock, synchronous active-high reset
//   i_start, i_stop        1-cycle pulses: clear+start measurement / end measurement (RUN only)
//   i_tx_data/i_tx_valid   reference word stream, o_tx_ready accepts (push = valid & ready)
//   i_rx_data/i_rx_valid   decoded word stream under test, compared against the FIFO head
//   i_chan_err_valid       one injected channel error this cycle
//   o_*_count              saturating statistics counters for the current measurement
//   o_busy, o_done         state == RUN / state == DONE
//   o_pass                 result, valid while o_done
//   o_underrun             sticky: RX beat arrived while the FIFO was empty
module ber_monitor #(
   parameter int DATA_W       = 1,
   parameter int DEPTH        = 64,
   parameter int CNT_W        = 32,
   parameter int WINDOW_WORDS = 0,
   parameter int ERR_THRESH   = 0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   input  logic [DATA_W-1:0] i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_chan_err_valid,
   output logic [CNT_W-1:0]  o_tx_count,
   output logic [CNT_W-1:0]  o_rx_count,
   output logic [CNT_W-1:0]  o_bit_err_count,
   output logic [CNT_W-1:0]  o_word_err_count,
   output logic [CNT_W-1:0]  o_chan_err_count,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_underrun
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PC_W  = $clog2(DATA_W + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic [CNT_W-1:0]    r_tx_cnt;
   logic [CNT_W-1:0]    r_rx_cnt;
   logic [CNT_W-1:0]    r_bit_err;
   logic [CNT_W-1:0]    r_word_err;
   logic [CNT_W-1:0]    r_chan_err;
   logic                r_pass;
   logic                r_underrun;

   logic                w_run;
   logic                w_empty;
   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic [DATA_W-1:0]   w_diff;
   logic [PC_W-1:0]     w_popcnt;
   logic [SUM_W-1:0]    w_bit_sum;
   logic [CNT_W-1:0]    w_bit_err_nxt;
   logic [CNT_W-1:0]    w_rx_nxt;
   logic                w_win_hit;
   logic                w_enter_done;
   logic                w_pass_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_run   = (r_state == S_RUN);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = w_run & i_tx_valid & ~w_full;
   // Pop decision uses pre-push occupancy: a word written this cycle is never compared this cycle.
   assign w_pop   = w_run & i_rx_valid & ~w_empty;
   assign w_diff  = i_rx_data ^ r_mem[r_rd_ptr[AW-1:0]];

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_popcnt = w_popcnt + PC_W'(w_diff[i]);
      end
   end

   assign w_bit_sum     = SUM_W'(r_bit_err) + SUM_W'(w_popcnt);
   assign w_bit_err_nxt = (w_bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_bit_sum[CNT_W-1:0];
   assign w_rx_nxt      = sat_inc(r_rx_cnt);
   assign w_win_hit     = (WINDOW_WORDS != 0) && w_pop && (w_rx_nxt == CNT_W'(WINDOW_WORDS));

   // PASS must see the final beat's contribution, so evaluate on post-update values.
   assign w_pass_nxt = ((w_pop ? w_bit_err_nxt : r_bit_err) <= CNT_W'(ERR_THRESH)) &&
                       !(r_underrun || (i_rx_valid && w_empty));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (i_start) w_state_nxt = S_RUN;
                  else if (i_stop || w_win_hit) w_state_nxt = S_DONE;
         S_DONE:  if (i_start) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_done = w_run && (w_state_nxt == S_DONE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_start) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_tx_cnt   <= '0;
         r_rx_cnt   <= '0;
         r_bit_err  <= '0;
         r_word_err <= '0;
         r_chan_err <= '0;
         r_pass     <= 1'b0;
         r_underrun <= 1'b0;
      end else if (w_run) begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            r_tx_cnt <= sat_inc(r_tx_cnt);
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + (AW+1)'(1);
            r_rx_cnt  <= w_rx_nxt;
            r_bit_err <= w_bit_err_nxt;
            if (w_popcnt != '0) r_word_err <= sat_inc(r_word_err);
         end
         if (i_rx_valid && w_empty) r_underrun <= 1'b1;
         if (i_chan_err_valid)      r_chan_err <= sat_inc(r_chan_err);
         if (w_enter_done)          r_pass     <= w_pass_nxt;
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_tx_data;
   end

   assign o_tx_ready       = w_run & ~w_full;
   assign o_tx_count       = r_tx_cnt;
   assign o_rx_count       = r_rx_cnt;
   assign o_bit_err_count  = r_bit_err;
   assign o_word_err_count = r_word_err;
   assign o_chan_err_count = r_chan_err;
   assign o_busy           = (r_state == S_RUN);
   assign o_done           = (r_state == S_DONE);
   assign o_pass           = r_pass;
   assign o_underrun       = r_underrun;

endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: randomized scoreboard bench for ber_monitor.
// Stimulus process drives one cycle at a time and queues the expected post-edge outputs;
// a monitor process pops and compares after every rising edge.
module tb_ber_monitor;

   localparam int DW   = 8;
   localparam int DP   = 16;
   localparam int CW   = 5;
   localparam int WIN  = 20;
   localparam int THR  = 2;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct packed {
      logic          rdy;
      logic          busy;
      logic          done;
      logic          pass;
      logic          under;
      logic [CW-1:0] tx;
      logic [CW-1:0] rx;
      logic [CW-1:0] bits;
      logic [CW-1:0] words;
      logic [CW-1:0] chan;
   } snap_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          chan_err = 1'b0;
   logic [CW-1:0] tx_count, rx_count, bit_err_count, word_err_count, chan_err_count;
   logic          busy, done, pass, underrun;

   always #5 clk = ~clk;

   ber_monitor #(
      .DATA_W(DW), .DEPTH(DP), .CNT_W(CW), .WINDOW_WORDS(WIN), .ERR_THRESH(THR)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
      .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_chan_err_valid(chan_err),
      .o_tx_count(tx_count), .o_rx_count(rx_count), .o_bit_err_count(bit_err_count),
      .o_word_err_count(word_err_count), .o_chan_err_count(chan_err_count),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_underrun(underrun)
   );

   // Reference model: measurement state, reference words as a plain queue, integer stats.
   int            m_st;   // 0 idle, 1 measuring, 2 finished
   logic [DW-1:0] m_q[$];
   int            m_tx, m_rx, m_bit, m_word, m_chan;
   bit            m_pass, m_under;

   snap_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_tx = 0; m_rx = 0; m_bit = 0; m_word = 0; m_chan = 0;
      m_pass = 0; m_under = 0;
   endtask

   task automatic model_step(input bit rst, input bit st, input bit sp, input bit tv,
                             input bit rv, input bit ce, input logic [DW-1:0] txd,
                             input logic [DW-1:0] rxd);
      bit            can_push;
      bit            popped;
      logic [DW-1:0] refw;
      int            nerr;
      popped = 0;
      if (rst) begin
         model_clear();
         m_st = 0;
      end else if (st) begin
         model_clear();
         m_st = 1;
      end else if (m_st == 1) begin
         can_push = (m_q.size() < DP);
         if (rv) begin
            if (m_q.size() == 0) begin
               m_under = 1;
            end else begin
               refw   = m_q.pop_front();
               popped = 1;
               nerr   = $countones(rxd ^ refw);
               m_rx   = sat(m_rx + 1);
               m_bit  = sat(m_bit + nerr);
               if (nerr > 0) m_word = sat(m_word + 1);
            end
         end
         if (tv && can_push) begin
            m_q.push_back(txd);
            m_tx = sat(m_tx + 1);
         end
         if (ce) m_chan = sat(m_chan + 1);
         if (sp || (popped && m_rx == WIN)) begin
            m_st   = 2;
            m_pass = (m_bit <= THR) && !m_under;
         end
      end
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.rdy   = (m_st == 1) && (m_q.size() < DP);
      s.busy  = (m_st == 1);
      s.done  = (m_st == 2);
      s.pass  = m_pass;
      s.under = m_under;
      s.tx    = CW'(m_tx);
      s.rx    = CW'(m_rx);
      s.bits  = CW'(m_bit);
      s.words = CW'(m_word);
      s.chan  = CW'(m_chan);
      return s;
   endfunction

   task automatic drive(input bit rst, input bit st, input bit sp, input bit tv,
                        input bit rv, input bit ce, input logic [DW-1:0] txd,
                        input logic [DW-1:0] rxd);
      @(negedge clk);
      reset = rst; start = st; stop = sp;
      tx_valid = tv; tx_data = txd;
      rx_valid = rv; rx_data = rxd;
      chan_err = ce;
      model_step(rst, st, sp, tv, rv, ce, txd, rxd);
      exp_q.push_back(model_snap());
   endtask

   // RX data tracks the model's head so clean runs match; errors are XOR masks on top.
   task automatic rand_cycle(input int tx_pct, input int rx_pct, input int err_pct,
                             input int ce_pct, input bit sp);
      bit            tv, rv, ce;
      logic [DW-1:0] txd, rxd;
      tv  = ($urandom_range(99) < tx_pct);
      rv  = ($urandom_range(99) < rx_pct);
      ce  = ($urandom_range(99) < ce_pct);
      txd = DW'($urandom);
      rxd = (m_q.size() > 0) ? m_q[0] : DW'($urandom);
      if ($urandom_range(99) < err_pct) rxd = rxd ^ DW'($urandom_range(255, 1));
      drive(1'b0, 1'b0, sp, tv, rv, ce, txd, rxd);
   endtask

   // Monitor: one comparison of the full output vector after every edge that has an expectation.
   initial begin
      snap_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{rdy: tx_ready, busy: busy, done: done, pass: pass, under: underrun,
                  tx: tx_count, rx: rx_count, bits: bit_err_count, words: word_err_count,
                  chan: chan_err_count};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL outputs t=%0t actual rdy/busy/done/pass/und=%b%b%b%b%b tx=%0d rx=%0d bit=%0d word=%0d chan=%0d | required rdy/busy/done/pass/und=%b%b%b%b%b tx=%0d rx=%0d bit=%0d word=%0d chan=%0d",
                        $time, a.rdy, a.busy, a.done, a.pass, a.under, a.tx, a.rx, a.bits,
                        a.words, a.chan, e.rdy, e.busy, e.done, e.pass, e.under, e.tx, e.rx,
                        e.bits, e.words, e.chan);
            end
         end
      end
   end

   initial begin
      int kind;
      m_st = 0;
      model_clear();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A);
      // Idle traffic must be ignored.
      for (int i = 0; i < 3; i++) rand_cycle(100, 100, 50, 100, 1'b1);

      for (int m = 0; m < 24; m++) begin
         kind = m % 4;
         // Occasionally START and STOP together: START must win.
         drive(1'b0, 1'b1, ($urandom_range(3) == 0), 1'b1, 1'b1, 1'b1,
               DW'($urandom), DW'($urandom));
         for (int c = 0; c < 70; c++) begin
            if (m == 5 && c == 30) begin
               drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
            end else if (m == 9 && c == 12) begin
               drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44);
            end else begin
               case (kind)
                  0: rand_cycle(100, (c < 10) ? 0 : 100, 0, 0, 1'b0);          // clean, RX lags
                  1: rand_cycle(70, (c < 25) ? 0 : 60, 15, 10, 1'b0);          // fill to full, sparse errors
                  2: rand_cycle((c < 5) ? 0 : 80, 50, 5, 0, 1'b0);             // RX before TX: underrun
                  default: rand_cycle(80, 60, 90, 30, (c == 25));              // saturating errors, early STOP
               endcase
            end
         end
      end

      for (int i = 0; i < 3; i++) rand_cycle(0, 0, 0, 0, 1'b0);
      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
